// File: rtl/motor_pkg.sv
// Shared types and constants for the motor command sequencer.
// The emergency-stop sweep is enabled by defining MOTOR_SEQ_ESTOP_EN.
package motor_pkg;

   localparam int         DEFAULT_NUM_MOTORS = 6;
   localparam logic [7:0] DEFAULT_IDLE_CODE  = 8'hFF;
   localparam int         STATE_EN_BIT       = 0;
   localparam int         STATE_AUX_BIT      = 1;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      SWEEP = 2'd1,
      HOLD  = 2'd2
   } seq_state_t;

   typedef struct packed {
      logic [7:0] motor;
      logic [1:0] state;
   } motor_cmd_t;

endpackage

// File: rtl/motor_cmd_fifo.sv
// Synchronous command FIFO with push/pop/flush and occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module motor_cmd_fifo
   import motor_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     i_push,
   input  motor_cmd_t               i_data,
   input  logic                     i_pop,
   input  logic                     i_flush,
   output motor_cmd_t               o_head,
   output logic                     o_empty,
   output logic                     o_full,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   motor_cmd_t    r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_do_push;
   logic          w_do_pop;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == CW'(DEPTH));
   assign o_head    = r_mem[r_rd_ptr];
   assign o_count   = r_count;
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   // Flush wins over any push or pop on the same edge.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         if (w_do_push && !w_do_pop) begin
            r_count <= r_count + CW'(1);
         end else if (!w_do_push && w_do_pop) begin
            r_count <= r_count - CW'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (w_do_push && !i_flush) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

endmodule

// File: rtl/motor_command_sequencer.sv
// Buffers motor on/off commands and issues them one per cycle, spacing enable-ons by GAP_CYCLES.
// Define MOTOR_SEQ_ESTOP_EN to add the estop input and the SWEEP/HOLD shutdown sequence.
module motor_command_sequencer
   import motor_pkg::*;
#(
   parameter int         NUM_MOTORS = DEFAULT_NUM_MOTORS,
   parameter int         FIFO_DEPTH = 4,
   parameter int         GAP_CYCLES = 50000,
   parameter logic [7:0] IDLE_CODE  = DEFAULT_IDLE_CODE
)(
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic [7:0]                    cmd_motor,
   input  logic [1:0]                    cmd_state,
   input  logic                          err_clr,
`ifdef MOTOR_SEQ_ESTOP_EN
   input  logic                          estop,
`endif
   output logic [7:0]                    motor,
   output logic [1:0]                    state,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          err_bad_id
);

   localparam int         GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);
   localparam logic [8:0] ID_LIMIT = 9'(NUM_MOTORS);
   localparam logic [7:0] LAST_ID  = 8'(NUM_MOTORS - 1);

   seq_state_t    r_seq_state;
   logic [7:0]    r_sweep_idx;
   logic [GW-1:0] r_gap;
   logic [7:0]    r_motor;
   logic [1:0]    r_state;
   logic          r_started;
   logic          r_err;

   motor_cmd_t    w_head;
   motor_cmd_t    w_new_cmd;
   logic          w_empty;
   logic          w_full;
   logic          w_estop;
   logic          w_run;
   logic          w_estop_hit;
   logic          w_fire;
   logic          w_accept;
   logic          w_bad_id;
   logic          w_push;
   logic          w_head_en;
   logic          w_pop;

`ifdef MOTOR_SEQ_ESTOP_EN
   assign w_estop = estop;
`else
   assign w_estop = 1'b0;
`endif

   // An estop seen in RUN flushes the queue and drops any command handshaking on that edge.
   assign w_run       = (r_seq_state == RUN);
   assign w_estop_hit = w_estop && w_run;
   assign cmd_ready   = r_started && !w_full && w_run;
   assign w_fire      = cmd_valid && cmd_ready;
   assign w_accept    = w_fire && !w_estop_hit;
   assign w_bad_id    = ({1'b0, cmd_motor} >= ID_LIMIT);
   assign w_push      = w_accept && !w_bad_id;
   assign w_new_cmd   = '{motor: cmd_motor, state: cmd_state};

   // Disables always go; an enable-on at the head waits for the gap and blocks everything behind it.
   assign w_head_en   = w_head.state[STATE_EN_BIT];
   assign w_pop       = w_run && !w_estop && !w_empty && (!w_head_en || (r_gap == '0));

   assign motor       = r_motor;
   assign state       = r_state;
   assign err_bad_id  = r_err;
   assign busy        = !w_empty || (r_gap != '0) || (r_seq_state == SWEEP);

   motor_cmd_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .i_push  (w_push),
      .i_data  (w_new_cmd),
      .i_pop   (w_pop),
      .i_flush (w_estop_hit),
      .o_head  (w_head),
      .o_empty (w_empty),
      .o_full  (w_full),
      .o_count (fifo_count)
   );

   // Holds cmd_ready low until the first edge after reset release.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_started <= 1'b0;
      end else begin
         r_started <= 1'b1;
      end
   end

   // A new bad id on the same edge as err_clr keeps the flag set.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_err <= 1'b0;
      end else if (w_accept && w_bad_id) begin
         r_err <= 1'b1;
      end else if (err_clr) begin
         r_err <= 1'b0;
      end
   end

   // Sequencer FSM with the gap counter and the registered output bus.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_seq_state <= RUN;
         r_sweep_idx <= '0;
         r_gap       <= '0;
         r_motor     <= IDLE_CODE;
         r_state     <= 2'b00;
      end else begin
         r_motor <= IDLE_CODE;
         r_state <= 2'b00;
         unique case (r_seq_state)
            RUN: begin
               if (w_estop) begin
                  r_seq_state <= SWEEP;
                  r_sweep_idx <= '0;
                  r_gap       <= '0;
               end else begin
                  if (w_pop) begin
                     r_motor <= w_head.motor;
                     r_state <= w_head.state;
                  end
                  if (w_pop && w_head_en) begin
                     r_gap <= GAP_LOAD;
                  end else if (r_gap != '0) begin
                     r_gap <= r_gap - GW'(1);
                  end
               end
            end
            SWEEP: begin
               r_motor <= r_sweep_idx;
               r_state <= 2'b00;
               if (r_sweep_idx == LAST_ID) begin
                  r_seq_state <= HOLD;
               end else begin
                  r_sweep_idx <= r_sweep_idx + 8'd1;
               end
            end
            HOLD: begin
               if (!w_estop) begin
                  r_seq_state <= RUN;
               end
            end
            default: begin
               r_seq_state <= RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_motor_command_sequencer.sv
// Self-checking bench for motor_command_sequencer with GAP_CYCLES=4, FIFO_DEPTH=4, six motors.
// Define MOTOR_SEQ_ESTOP_EN to also exercise the estop sweep.
`timescale 1ns/1ps
module tb_motor_command_sequencer;
   import motor_pkg::*;

   localparam int         NUM_MOTORS = 6;
   localparam int         FIFO_DEPTH = 4;
   localparam int         GAP_CYCLES = 4;
   localparam logic [7:0] IDLE       = 8'hFF;
   localparam int         NV         = 8;

   logic       clock     = 1'b0;
   logic       reset_n   = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       err_clr   = 1'b0;
   logic [7:0] cmd_motor = 8'd0;
   logic [1:0] cmd_state = 2'b00;
   logic       cmd_ready;
   logic [7:0] motor;
   logic [1:0] state;
   logic       busy;
   logic [2:0] fifo_count;
   logic       err_bad_id;
`ifdef MOTOR_SEQ_ESTOP_EN
   logic       estop = 1'b0;
`endif

   int checks      = 0;
   int errors      = 0;
   int cycleCount  = 0;
   int lastEnIssue = -1;
   bit monitorOn   = 1'b1;
   motor_cmd_t sb[$];
   int issueLog[$];

   typedef struct {
      logic [7:0] motor;
      logic [1:0] st;
      logic       expBad;
      logic [7:0] expMotor;
      logic [1:0] expState;
      int         expCount;
   } vec_t;
   vec_t vecs[NV];

   motor_command_sequencer #(
      .NUM_MOTORS (NUM_MOTORS),
      .FIFO_DEPTH (FIFO_DEPTH),
      .GAP_CYCLES (GAP_CYCLES),
      .IDLE_CODE  (IDLE)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_motor  (cmd_motor),
      .cmd_state  (cmd_state),
      .err_clr    (err_clr),
`ifdef MOTOR_SEQ_ESTOP_EN
      .estop      (estop),
`endif
      .motor      (motor),
      .state      (state),
      .busy       (busy),
      .fifo_count (fifo_count),
      .err_bad_id (err_bad_id)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cycleCount++;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d (cycle %0d)", name, actual, expected, cycleCount);
      end
   endtask

   // Called at a negedge; completes one handshake and returns at the negedge after it.
   task automatic applyStimulus(input logic [7:0] m, input logic [1:0] s);
      motor_cmd_t c;
      int n = 0;
      while (!cmd_ready && n < 100) begin
         @(negedge clock);
         n++;
      end
      checkOutput("handshake_ready", int'(cmd_ready), 1);
      cmd_valid = 1'b1;
      cmd_motor = m;
      cmd_state = s;
      if (m < NUM_MOTORS) begin
         c.motor = m;
         c.state = s;
         sb.push_back(c);
      end
      @(negedge clock);
      cmd_valid = 1'b0;
   endtask

   task automatic waitIdle(input string tag);
      int n = 0;
      while ((busy || !cmd_ready) && n < 200) begin
         @(negedge clock);
         n++;
      end
      checkOutput({tag, "_idle"}, int'(busy), 0);
   endtask

   // Scoreboard monitor: every issued command must match the next accepted one, in order.
   always @(negedge clock) begin
      motor_cmd_t e;
      if (monitorOn && reset_n && motor != IDLE) begin
         issueLog.push_back(cycleCount);
         if (sb.size() == 0) begin
            checkOutput("sb_unexpected_issue", int'(motor), int'(IDLE));
         end else begin
            e = sb.pop_front();
            checkOutput("sb_motor", int'(motor), int'(e.motor));
            checkOutput("sb_state", int'(state), int'(e.state));
         end
         if (state[0]) begin
            if (lastEnIssue >= 0) begin
               checkOutput("sb_enable_gap", int'((cycleCount - lastEnIssue) >= GAP_CYCLES), 1);
            end
            lastEnIssue = cycleCount;
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired at cycle %0d", cycleCount);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int k0;
      int expIssue[4];

      vecs[0] = '{8'd2,   2'b01, 1'b0, 8'd2, 2'b01, 1};
      vecs[1] = '{8'd3,   2'b00, 1'b0, 8'd3, 2'b00, 1};
      vecs[2] = '{8'd5,   2'b11, 1'b0, 8'd5, 2'b11, 1};
      vecs[3] = '{8'd0,   2'b10, 1'b0, 8'd0, 2'b10, 1};
      vecs[4] = '{8'd6,   2'b01, 1'b1, IDLE, 2'b00, 0};
      vecs[5] = '{8'd255, 2'b00, 1'b1, IDLE, 2'b00, 0};
      vecs[6] = '{8'd4,   2'b01, 1'b0, 8'd4, 2'b01, 1};
      vecs[7] = '{8'd1,   2'b00, 1'b0, 8'd1, 2'b00, 1};

      #1 reset_n = 1'b0;
      repeat (3) @(negedge clock);
      checkOutput("rst_motor", int'(motor), int'(IDLE));
      checkOutput("rst_state", int'(state), 0);
      checkOutput("rst_ready", int'(cmd_ready), 0);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_count", int'(fifo_count), 0);
      checkOutput("rst_err", int'(err_bad_id), 0);
      reset_n = 1'b1;
      @(negedge clock);
      checkOutput("ready_after_release", int'(cmd_ready), 1);

      $display("[TB] table-driven single commands");
      for (int i = 0; i < NV; i++) begin
         waitIdle($sformatf("vec%0d", i));
         applyStimulus(vecs[i].motor, vecs[i].st);
         checkOutput($sformatf("vec%0d_count", i), int'(fifo_count), vecs[i].expCount);
         @(negedge clock);
         checkOutput($sformatf("vec%0d_motor", i), int'(motor), int'(vecs[i].expMotor));
         checkOutput($sformatf("vec%0d_state", i), int'(state), int'(vecs[i].expState));
         checkOutput($sformatf("vec%0d_err", i), int'(err_bad_id), int'(vecs[i].expBad));
         @(negedge clock);
         checkOutput($sformatf("vec%0d_idle_motor", i), int'(motor), int'(IDLE));
         checkOutput($sformatf("vec%0d_idle_state", i), int'(state), 0);
         if (vecs[i].expBad) begin
            err_clr = 1'b1;
            @(negedge clock);
            err_clr = 1'b0;
            checkOutput($sformatf("vec%0d_err_clr", i), int'(err_bad_id), 0);
         end
      end

      $display("[TB] bad id set beats err_clr");
      waitIdle("setwins");
      err_clr = 1'b1;
      applyStimulus(8'd7, 2'b01);
      err_clr = 1'b0;
      checkOutput("setwins_err", int'(err_bad_id), 1);
      checkOutput("setwins_count", int'(fifo_count), 0);
      err_clr = 1'b1;
      @(negedge clock);
      err_clr = 1'b0;
      checkOutput("setwins_cleared", int'(err_bad_id), 0);

      $display("[TB] enable spacing and stalled disable");
      waitIdle("spacing");
      issueLog.delete();
      applyStimulus(8'd0, 2'b01);
      k0 = cycleCount;
      applyStimulus(8'd1, 2'b01);
      applyStimulus(8'd2, 2'b01);
      applyStimulus(8'd0, 2'b00);
      for (int n = 0; n < 100 && issueLog.size() < 4; n++) @(negedge clock);
      expIssue = '{k0 + 1, k0 + 5, k0 + 9, k0 + 10};
      checkOutput("spacing_issue_count", issueLog.size(), 4);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("spacing_issue%0d_cycle", i),
                     (i < issueLog.size()) ? issueLog[i] : -1, expIssue[i]);
      end

      $display("[TB] full FIFO and concurrent push/pop");
      waitIdle("full");
      applyStimulus(8'd0, 2'b01);
      applyStimulus(8'd1, 2'b01);
      checkOutput("concurrent_count", int'(fifo_count), 1);
      applyStimulus(8'd2, 2'b01);
      applyStimulus(8'd3, 2'b01);
      applyStimulus(8'd4, 2'b01);
      checkOutput("full_ready", int'(cmd_ready), 0);
      checkOutput("full_count", int'(fifo_count), 4);
      cmd_valid = 1'b1;
      cmd_motor = 8'd5;
      cmd_state = 2'b01;
      @(negedge clock);
      checkOutput("after_pop_count", int'(fifo_count), 3);
      checkOutput("after_pop_ready", int'(cmd_ready), 1);
      sb.push_back('{motor: 8'd5, state: 2'b01});
      @(negedge clock);
      cmd_valid = 1'b0;
      checkOutput("refill_count", int'(fifo_count), 4);
      waitIdle("drain");
      checkOutput("full_sb_drained", sb.size(), 0);

      $display("[TB] reset in the middle of a gap");
      waitIdle("rstgap");
      applyStimulus(8'd1, 2'b01);
      applyStimulus(8'd2, 2'b01);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("rstgap_motor", int'(motor), int'(IDLE));
      checkOutput("rstgap_state", int'(state), 0);
      checkOutput("rstgap_ready", int'(cmd_ready), 0);
      checkOutput("rstgap_busy", int'(busy), 0);
      checkOutput("rstgap_count", int'(fifo_count), 0);
      sb.delete();
      lastEnIssue = -1;
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      applyStimulus(8'd3, 2'b01);
      @(negedge clock);
      checkOutput("rstgap_next_motor", int'(motor), 3);
      checkOutput("rstgap_next_state", int'(state), 1);

`ifdef MOTOR_SEQ_ESTOP_EN
      $display("[TB] estop sweep");
      waitIdle("estop");
      applyStimulus(8'd1, 2'b01);
      applyStimulus(8'd2, 2'b01);
      applyStimulus(8'd3, 2'b01);
      applyStimulus(8'd4, 2'b00);
      checkOutput("estop_pre_count", int'(fifo_count), 3);
      monitorOn = 1'b0;
      estop = 1'b1;
      @(negedge clock);
      checkOutput("estop_flush_count", int'(fifo_count), 0);
      checkOutput("estop_ready", int'(cmd_ready), 0);
      checkOutput("estop_busy", int'(busy), 1);
      checkOutput("estop_entry_motor", int'(motor), int'(IDLE));
      for (int i = 0; i < NUM_MOTORS; i++) begin
         @(negedge clock);
         checkOutput($sformatf("sweep%0d_motor", i), int'(motor), i);
         checkOutput($sformatf("sweep%0d_state", i), int'(state), 0);
      end
      @(negedge clock);
      checkOutput("hold_motor", int'(motor), int'(IDLE));
      checkOutput("hold_ready", int'(cmd_ready), 0);
      estop = 1'b0;
      @(negedge clock);
      checkOutput("resume_ready", int'(cmd_ready), 1);
      sb.delete();
      lastEnIssue = -1;
      monitorOn = 1'b1;
      applyStimulus(8'd5, 2'b01);
      @(negedge clock);
      checkOutput("resume_motor", int'(motor), 5);
`endif

      waitIdle("final");
      checkOutput("final_sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/motor_command_sequencer.md
# motor_command_sequencer

- Upstream stage of the motor enable register.
- Accepts motor on/off commands from the HW/SW interface over a valid/ready handshake and buffers them in a small FIFO.
- Issues them one per cycle on the `motor`/`state` bus that the enable register samples.
- Enforces a minimum spacing between successive enable-on commands to limit inrush current; disable commands are never delayed by the spacing rule.

## Interface

Parameters:
- `NUM_MOTORS`, default 6: number of valid motor ids, 0..NUM_MOTORS-1.
- `FIFO_DEPTH`, default 4: command FIFO entries; power of 2, ≥2.
- `GAP_CYCLES`, default 50000: minimum cycles between two enable-on issues; ≥1.
- `IDLE_CODE`, default 8'hFF: `motor` value driven when no command is issued; must be ≥NUM_MOTORS.

Ports (one clock; reset is asynchronous and active-low):
- `clock` in 1: sole clock; all logic on posedge.
- `reset_n` in 1: asynchronous active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command.
- `cmd_motor` in 8: target motor id.
- `cmd_state` in 2: bit0 = enable value; bit1 passed through unmodified.
- `err_clr` in 1: clears `err_bad_id`.
- `estop` in 1: emergency stop, level-sensitive; present only with MOTOR_SEQ_ESTOP_EN.
- `motor` out 8: motor id to enable register.
- `state` out 2: state to enable register.
- `busy` out 1: FIFO non-empty, gap counter non-zero, or sweep active.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: current occupancy.
- `err_bad_id` out 1: sticky flag, set by an out-of-range command id.

## Operation

- **Handshake:** a transfer occurs on a posedge with `cmd_valid`=1 and `cmd_ready`=1. `cmd_ready` = !full, and is 0 during sweep. There is no same-cycle pass-through when full, even if a pop occurs that cycle.
- **Bad id:** `cmd_motor` ≥ NUM_MOTORS is accepted (handshake completes) but not written. It sets `err_bad_id`. `err_clr` clears the flag; a set on the same edge wins.
- **Issue rule:** evaluated every cycle on the FIFO head.
  - Head `state[0]`=0 (disable): pop and issue immediately, regardless of the gap counter.
  - Head `state[0]`=1 (enable-on): issue only when `gap_cnt`==0. Issuing loads `gap_cnt` = GAP_CYCLES-1.
  - No reordering: an enable-on blocked at the head stalls the disables queued behind it.
- **Gap counter:** `gap_cnt` decrements by 1 per cycle while non-zero, saturating at 0.
- **Output bus:** `motor`/`state` are registered.
  - A command is presented for exactly one cycle.
  - Otherwise `motor`=IDLE_CODE and `state`=2'b00, which the enable register ignores.
- **FSM (with MOTOR_SEQ_ESTOP_EN):**
  - RUN: normal operation as above.
  - SWEEP: entered on the first edge with `estop`=1. On entry the FIFO is flushed and `gap_cnt` is cleared. Issues motor 0,1,…,NUM_MOTORS-1 with `state`=2'b00 on consecutive cycles, then goes to HOLD.
  - HOLD: outputs idle, `cmd_ready`=0. Returns to RUN on the first edge with `estop`=0.
  - `estop` deasserting mid-sweep does not abort the sweep.
- **Reset values:**
  - `motor`=IDLE_CODE, `state`=0, `cmd_ready`=0 during reset and 1 from the first edge after release.
  - `busy`=0, `fifo_count`=0, `err_bad_id`=0.
  - FSM=RUN, `gap_cnt`=0.
  - Reset mid-sweep or mid-gap discards everything.

## Timing

- **Latency:** a command accepted at edge k into an empty FIFO with `gap_cnt`=0 is popped at edge k+1. `motor`/`state` are valid during cycle k+1→k+2, and the enable register updates EN at edge k+2.
- **Throughput:** 1 command/cycle for disables. For enable-ons, issue cycles differ by ≥GAP_CYCLES.
- **Simultaneous push and pop:** permitted when not full; `fifo_count` is unchanged.
- **Pointers:** wrap modulo FIFO_DEPTH.
- **Sweep:** starts issuing on the edge after `estop` is sampled high and lasts NUM_MOTORS cycles.
- **Estop priority:** `estop` sampled on the same edge as a handshake wins; that command is dropped.

## Configuration

- **MOTOR_SEQ_ESTOP_EN defined:** `estop` port exists, plus the SWEEP/HOLD behaviour above.
- **Undefined:** no `estop` port, the FSM is RUN only, and `cmd_ready` depends only on full.

## Structure

- **Package `motor_pkg`:**
  - Constants: NUM_MOTORS default, IDLE_CODE, state bit positions (STATE_EN_BIT=0).
  - `seq_state_t` enum {RUN, SWEEP, HOLD}.
  - Packed struct `motor_cmd_t` {motor[7:0], state[1:0]}.
- **Sub-module `motor_cmd_fifo`:** synchronous FIFO of `motor_cmd_t` with push/pop/flush/count. The sequencer owns the FSM, gap counter, and output registers.

## Test plan

- **Single enable:** GAP_CYCLES=4, push {motor 2, state 01} at edge 0 → `motor`=2, `state`=01 for one cycle after edge 1, then IDLE_CODE/00.
- **Spacing:** GAP_CYCLES=4, push on motors 0,1,2 back-to-back → issues at cycles 1, 5, 9. Then push off motor 0 → it issues the cycle after reaching the head.
- **Full and concurrent push/pop:** FIFO_DEPTH=4, fill with blocked enable-ons → `cmd_ready`=0 and `fifo_count`=4. One pop → `cmd_ready`=1 the next cycle, with no overrun or loss.
- **Bad id:** push motor 6 → no issue and `err_bad_id`=1. Assert `err_clr` → flag 0 the next cycle.
- **Estop (macro on):** assert `estop` with 3 entries queued → FIFO flushed, `motor` 0..5 with `state`=00 on 6 consecutive cycles, then idle with `cmd_ready`=0. Deassert → RUN, and a new command issues with no gap wait.
- **Reset mid-gap:** pulse `reset_n` low during `gap_cnt`=3 → all outputs at reset values, and the next enable-on issues with no wait.
